// File: rtl/bus_burst_read_master_if.sv
// bus_burst_read_master_if: shared multiplexed address/data bus between one master and its slaves
// Ports (master view): busRequestOut/busGrantIn arbitration; addressDataOut, beginTransactionOut,
// readNotWriteOut, endTransactionOut, byteEnablesOut, burstSizeOut driven by the master;
// addressDataIn, dataValidIn, endTransactionIn, busErrorIn returned by the slave.
interface bus_burst_read_master_if;
  logic        busRequestOut;
  logic        busGrantIn;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [31:0] addressDataOut;
  logic        beginTransactionOut;
  logic        readNotWriteOut;
  logic        endTransactionOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  modport master(
    output busRequestOut, addressDataOut, beginTransactionOut, readNotWriteOut, endTransactionOut, byteEnablesOut, burstSizeOut,
    input  busGrantIn, addressDataIn, dataValidIn, endTransactionIn, busErrorIn
  );
  modport slave(
    input  busRequestOut, addressDataOut, beginTransactionOut, readNotWriteOut, endTransactionOut, byteEnablesOut, burstSizeOut,
    output busGrantIn, addressDataIn, dataValidIn, endTransactionIn, busErrorIn
  );
endinterface

// File: rtl/bus_burst_read_master.sv
// bus_burst_read_master: single-client burst-read master on the shared multiplexed bus
module bus_burst_read_master #(parameter int TIMEOUT_CYCLES = 64) (
  input  logic        clock,
  input  logic        reset,
  input  logic        requestIn,
  input  logic [31:0] requestAddressIn,
  input  logic [7:0]  requestBurstSizeIn,
  output logic        busyOut,
  output logic [31:0] dataOut,
  output logic        dataValidOut,
  output logic [7:0]  wordIndexOut,
  output logic        doneOut,
  output logic        errorOut,
  bus_burst_read_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQUEST, BEGIN_TX, RECEIVE, ERRWAIT, ABORT, DONE} stateT;
  stateT state, nextState;
  logic [31:0] address;
  logic [7:0] size;
  logic [8:0] count;
  logic [8:0] received;
  logic accept, overflow, timeout, setError;
  assign accept = state == RECEIVE && bus.dataValidIn && !bus.busErrorIn && count <= {1'b0, size};
  assign overflow = state == RECEIVE && bus.dataValidIn && !bus.busErrorIn && count > {1'b0, size};
  assign received = count + {8'd0, accept};
  assign setError = (state == RECEIVE && (bus.busErrorIn || overflow ||
                     (bus.endTransactionIn && received != {1'b0, size} + 9'd1))) || nextState == ABORT;
`ifdef BUS_BURST_READ_MASTER_TIMEOUT_EN
  logic [15:0] watchdog;
  always_ff @(posedge clock or posedge reset)
    if (reset) watchdog <= '0;
    else watchdog <= (state == BEGIN_TX || bus.dataValidIn || bus.endTransactionIn) ? 16'd1 : watchdog + 16'd1;
  assign timeout = (state == RECEIVE || state == ERRWAIT) && !bus.dataValidIn && !bus.endTransactionIn &&
                   watchdog + 16'd1 == 16'(TIMEOUT_CYCLES);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     nextState = requestIn ? REQUEST : IDLE;
      REQUEST:  nextState = bus.busGrantIn ? BEGIN_TX : REQUEST;
      BEGIN_TX: nextState = RECEIVE;
      RECEIVE:  nextState = bus.endTransactionIn ? DONE : bus.busErrorIn ? ERRWAIT : timeout ? ABORT : RECEIVE;
      ERRWAIT:  nextState = bus.endTransactionIn ? DONE : timeout ? ABORT : ERRWAIT;
      ABORT:    nextState = DONE;
      default:  nextState = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      address <= '0;
      size <= '0;
      count <= '0;
      busyOut <= 1'b0;
      dataOut <= '0;
      dataValidOut <= 1'b0;
      wordIndexOut <= '0;
      doneOut <= 1'b0;
      errorOut <= 1'b0;
      bus.busRequestOut <= 1'b0;
      bus.addressDataOut <= '0;
      bus.beginTransactionOut <= 1'b0;
      bus.readNotWriteOut <= 1'b0;
      bus.endTransactionOut <= 1'b0;
      bus.byteEnablesOut <= '0;
      bus.burstSizeOut <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && requestIn) begin
        address <= requestAddressIn;
        size <= requestBurstSizeIn;
      end
      count <= state == BEGIN_TX ? 9'd0 : received;
      busyOut <= nextState != IDLE;
      doneOut <= nextState == DONE;
      errorOut <= (state == IDLE && requestIn) ? 1'b0 : errorOut | setError;
      dataValidOut <= accept;
      if (accept) begin
        dataOut <= bus.addressDataIn;
        wordIndexOut <= count[7:0];
      end
      bus.busRequestOut <= !(nextState inside {IDLE, DONE});
      bus.beginTransactionOut <= nextState == BEGIN_TX;
      bus.readNotWriteOut <= nextState == BEGIN_TX;
      bus.addressDataOut <= nextState == BEGIN_TX ? address : '0;
      bus.byteEnablesOut <= nextState == BEGIN_TX ? 4'hF : 4'h0;
      bus.burstSizeOut <= nextState == BEGIN_TX ? size : '0;
      bus.endTransactionOut <= nextState == ABORT;
    end
endmodule

// File: tb/tb_bus_burst_read_master.sv
// tb_bus_burst_read_master: randomized self-checking bench with a behavioural slave and reference model
`timescale 1ns/1ps
module tb_bus_burst_read_master;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic requestIn = 1'b0;
  logic [31:0] requestAddressIn = '0;
  logic [7:0] requestBurstSizeIn = '0;
  logic busyOut, dataValidOut, doneOut, errorOut;
  logic [31:0] dataOut;
  logic [7:0] wordIndexOut;
  int checks = 0, passed = 0, cyc = 0;

  bus_burst_read_master_if bus();

  bus_burst_read_master #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .requestIn(requestIn), .requestAddressIn(requestAddressIn),
    .requestBurstSizeIn(requestBurstSizeIn), .busyOut(busyOut), .dataOut(dataOut), .dataValidOut(dataValidOut),
    .wordIndexOut(wordIndexOut), .doneOut(doneOut), .errorOut(errorOut), .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] gotData[$];
  logic [7:0] gotIdx[$];
  int gotCyc[$];
  int doneCount = 0, doneCyc = -1, beginCount = 0, beginCyc = -1, strayCount = 0;
  int endOutCount = 0, endOutCyc = -1, busyRises = 0, busyCyc = -1, idleCyc = -1, busReqCyc = -1;
  logic doneErr = 1'b0, prevBusy = 1'b0, prevReq = 1'b0, beginRnw = 1'b0;
  logic [31:0] beginAddr = '0;
  logic [7:0] beginSize = '0;
  logic [3:0] beginBe = '0;
  always @(negedge clock) begin
    if (dataValidOut) begin
      gotData.push_back(dataOut);
      gotIdx.push_back(wordIndexOut);
      gotCyc.push_back(cyc);
    end
    if (doneOut) begin
      doneCount++;
      doneCyc = cyc;
      doneErr = errorOut;
    end
    if (bus.beginTransactionOut) begin
      beginCount++;
      beginCyc = cyc;
      beginAddr = bus.addressDataOut;
      beginSize = bus.burstSizeOut;
      beginBe = bus.byteEnablesOut;
      beginRnw = bus.readNotWriteOut;
    end else if (bus.addressDataOut != 0 || bus.burstSizeOut != 0 || bus.byteEnablesOut != 0 || bus.readNotWriteOut)
      strayCount++;
    if (bus.endTransactionOut) begin
      endOutCount++;
      endOutCyc = cyc;
    end
    if (busyOut && !prevBusy) begin
      busyRises++;
      busyCyc = cyc;
    end
    if (!busyOut && prevBusy) idleCyc = cyc;
    if (bus.busRequestOut && !prevReq) busReqCyc = cyc;
    prevBusy = busyOut;
    prevReq = bus.busRequestOut;
  end

  logic [31:0] sent[$];
  int sentCyc[$];
  int reqCyc, grantCyc, endCyc, gotBase, doneBase, beginBase, strayBase, busyBase, endOutBase;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic runBurst(input logic [31:0] addr, input logic [7:0] size, input int grantDelay, input int nWords,
                          input bit errSlave, input bit silent, input bit endWithLast, input logic [31:0] dataBase);
    int t;
    sent.delete();
    sentCyc.delete();
    gotBase = gotData.size();
    doneBase = doneCount;
    beginBase = beginCount;
    strayBase = strayCount;
    busyBase = busyRises;
    endOutBase = endOutCount;
    step();
    requestIn = 1'b1;
    requestAddressIn = addr;
    requestBurstSizeIn = size;
    reqCyc = cyc;
    step();
    requestIn = 1'b0;
    requestAddressIn = $urandom;
    requestBurstSizeIn = 8'($urandom);
    repeat (grantDelay) step();
    bus.busGrantIn = 1'b1;
    grantCyc = cyc;
    step();
    bus.busGrantIn = 1'b0;
    t = 0;
    while (beginCount == beginBase && t < 10) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (beginCount == beginBase) begin
      checks++;
      $display("FAIL begin_wait: no beginTransactionOut within 10 cycles of grant");
    end
    step();
    requestIn = 1'b1;
    requestAddressIn = $urandom;
    step();
    requestIn = 1'b0;
    step();
    if (errSlave) begin
      bus.busErrorIn = 1'b1;
      step();
      step();
      bus.endTransactionIn = 1'b1;
      endCyc = cyc;
      step();
      bus.busErrorIn = 1'b0;
      bus.endTransactionIn = 1'b0;
    end else if (!silent) begin
      for (int i = 0; i < nWords; i++) begin
        bus.dataValidIn = 1'b1;
        bus.addressDataIn = dataBase != 0 ? dataBase + 32'(i) : $urandom;
        sent.push_back(bus.addressDataIn);
        sentCyc.push_back(cyc);
        if (endWithLast && i == nWords - 1) begin
          bus.endTransactionIn = 1'b1;
          endCyc = cyc;
        end
        step();
        bus.dataValidIn = 1'b0;
        bus.endTransactionIn = 1'b0;
        bus.addressDataIn = '0;
        repeat ($urandom_range(0, 2)) step();
      end
      if (!(endWithLast && nWords > 0)) begin
        bus.endTransactionIn = 1'b1;
        endCyc = cyc;
        step();
        bus.endTransactionIn = 1'b0;
      end
    end
    t = 0;
    while (doneCount == doneBase && t < 40) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (doneCount == doneBase) begin
      checks++;
      $display("FAIL done_wait: no doneOut within 40 cycles");
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({busyOut, dataValidOut, doneOut, errorOut, dataOut, wordIndexOut} !== '0)
      $display("FAIL reset_client: got %h, expected 0", {busyOut, dataValidOut, doneOut, errorOut, dataOut, wordIndexOut});
    else passed++;
    checks++;
    if ({bus.busRequestOut, bus.addressDataOut, bus.beginTransactionOut, bus.readNotWriteOut, bus.endTransactionOut,
         bus.byteEnablesOut, bus.burstSizeOut} !== '0)
      $display("FAIL reset_bus: bus outputs nonzero, addressDataOut %h", bus.addressDataOut);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    runBurst(32'hF0000000, 8'd3, 1, 4, 1'b0, 1'b0, 1'b0, 32'hA0);
    checks++;
    if ({beginAddr, beginSize, beginBe, beginRnw} !== {32'hF0000000, 8'd3, 4'hF, 1'b1})
      $display("FAIL nominal_begin: got addr %h size %0d be %h rnw %b, expected F0000000 3 f 1", beginAddr, beginSize, beginBe, beginRnw);
    else passed++;
    checks++;
    if (busyCyc !== reqCyc + 1 || busReqCyc !== reqCyc + 1)
      $display("FAIL nominal_busy: busy at %0d busRequest at %0d, expected %0d", busyCyc, busReqCyc, reqCyc + 1);
    else passed++;
    checks++;
    if (beginCyc !== reqCyc + 3) $display("FAIL nominal_begin_time: got %0d, expected %0d", beginCyc, reqCyc + 3);
    else passed++;
    checks++;
    if (gotData.size() - gotBase !== 4) $display("FAIL nominal_count: got %0d words, expected 4", gotData.size() - gotBase);
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gotData[gotBase + i] !== 32'hA0 + 32'(i) || gotIdx[gotBase + i] !== 8'(i) || gotCyc[gotBase + i] !== sentCyc[i] + 1)
          $display("FAIL nominal_word%0d: got %h idx %0d at %0d, expected %h idx %0d at %0d", i, gotData[gotBase + i],
                   gotIdx[gotBase + i], gotCyc[gotBase + i], 32'hA0 + 32'(i), i, sentCyc[i] + 1);
        else passed++;
      end
      checks++;
      if (gotCyc[gotBase] !== beginCyc + 4) $display("FAIL nominal_first_latency: got %0d, expected %0d", gotCyc[gotBase], beginCyc + 4);
      else passed++;
    end
    checks++;
    if (doneCount - doneBase !== 1 || doneErr !== 1'b0)
      $display("FAIL nominal_done: got %0d pulses error %b, expected 1 pulse error 0", doneCount - doneBase, doneErr);
    else passed++;
    checks++;
    if (doneCyc !== endCyc + 1 || idleCyc !== endCyc + 2)
      $display("FAIL nominal_end_timing: done %0d idle %0d, expected %0d %0d", doneCyc, idleCyc, endCyc + 1, endCyc + 2);
    else passed++;
  endtask

  task automatic test_grant_delay();
    runBurst({$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 8'd1, 10, 2, 1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (beginCyc !== grantCyc + 1) $display("FAIL grant_delay_begin: got %0d, expected %0d", beginCyc, grantCyc + 1);
    else passed++;
    checks++;
    if (strayCount - strayBase !== 0 || beginCount - beginBase !== 1)
      $display("FAIL grant_delay_quiet: stray %0d begins %0d, expected 0 and 1", strayCount - strayBase, beginCount - beginBase);
    else passed++;
    checks++;
    if (gotData.size() - gotBase !== 2 || doneErr !== 1'b0)
      $display("FAIL grant_delay_result: got %0d words error %b, expected 2 error 0", gotData.size() - gotBase, doneErr);
    else passed++;
  endtask

  task automatic test_bus_error();
    runBurst(32'hF0000002, 8'd2, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (beginAddr !== 32'hF0000002) $display("FAIL bus_error_addr: got %h, expected F0000002", beginAddr);
    else passed++;
    checks++;
    if (gotData.size() - gotBase !== 0 || doneCount - doneBase !== 1 || doneErr !== 1'b1)
      $display("FAIL bus_error_result: words %0d done %0d error %b, expected 0 1 1", gotData.size() - gotBase, doneCount - doneBase, doneErr);
    else passed++;
  endtask

  task automatic test_short_burst();
    runBurst(32'hF0000010, 8'd3, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (gotData.size() - gotBase !== 2 || doneErr !== 1'b1)
      $display("FAIL short_result: words %0d error %b, expected 2 1", gotData.size() - gotBase, doneErr);
    else begin
      passed++;
      checks++;
      if (gotData[gotBase + 1] !== sent[1] || gotIdx[gotBase + 1] !== 8'd1)
        $display("FAIL short_word1: got %h idx %0d, expected %h idx 1", gotData[gotBase + 1], gotIdx[gotBase + 1], sent[1]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int size, nWords, expN, sel;
      logic expErr;
      size = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      nWords = sel == 0 ? size : sel == 1 ? size + 2 : size + 1;
      runBurst({$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 8'(size), $urandom_range(0, 4), nWords, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 32'h0);
      expN = nWords < size + 1 ? nWords : size + 1;
      expErr = nWords != size + 1;
      checks++;
      if (gotData.size() - gotBase !== expN || doneErr !== expErr || doneCyc !== endCyc + 1)
        $display("FAIL random%0d_result: words %0d error %b done %0d, expected %0d %b %0d", n, gotData.size() - gotBase,
                 doneErr, doneCyc, expN, expErr, endCyc + 1);
      else begin
        passed++;
        for (int i = 0; i < expN; i++) begin
          checks++;
          if (gotData[gotBase + i] !== sent[i] || gotIdx[gotBase + i] !== 8'(i) || gotCyc[gotBase + i] !== sentCyc[i] + 1)
            $display("FAIL random%0d_word%0d: got %h idx %0d, expected %h idx %0d", n, i, gotData[gotBase + i], gotIdx[gotBase + i], sent[i], i);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      runBurst({$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 8'd0, 0, 1, 1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (busyRises - busyBase !== 1 || beginCount - beginBase !== 1 || doneErr !== 1'b0)
        $display("FAIL back_to_back%0d: busy periods %0d begins %0d error %b, expected 1 1 0", n, busyRises - busyBase,
                 beginCount - beginBase, doneErr);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    step();
    requestIn = 1'b1;
    requestAddressIn = 32'hF0000000;
    requestBurstSizeIn = 8'd3;
    step();
    requestIn = 1'b0;
    step();
    bus.busGrantIn = 1'b1;
    step();
    bus.busGrantIn = 1'b0;
    repeat (3) step();
    bus.dataValidIn = 1'b1;
    bus.addressDataIn = 32'h11;
    step();
    bus.addressDataIn = 32'h22;
    step();
    bus.dataValidIn = 1'b0;
    bus.addressDataIn = '0;
    checks++;
    if ({dataValidOut, wordIndexOut, dataOut} !== {1'b1, 8'd1, 32'h22})
      $display("FAIL reset_mid_word1: got valid %b idx %0d data %h, expected 1 1 00000022", dataValidOut, wordIndexOut, dataOut);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busyOut, dataValidOut, doneOut, errorOut, dataOut, wordIndexOut} !== '0)
      $display("FAIL reset_mid_client: got %h, expected 0", {busyOut, dataValidOut, doneOut, errorOut, dataOut, wordIndexOut});
    else passed++;
    checks++;
    if ({bus.busRequestOut, bus.addressDataOut, bus.beginTransactionOut, bus.readNotWriteOut, bus.endTransactionOut,
         bus.byteEnablesOut, bus.burstSizeOut} !== '0)
      $display("FAIL reset_mid_bus: busRequestOut %b endTransactionOut %b, expected all 0", bus.busRequestOut, bus.endTransactionOut);
    else passed++;
    step();
    reset = 1'b0;
    runBurst(32'hF0000020, 8'd2, 1, 3, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (gotData.size() - gotBase !== 3 || doneErr !== 1'b0)
      $display("FAIL reset_mid_recover: words %0d error %b, expected 3 0", gotData.size() - gotBase, doneErr);
    else passed++;
  endtask

`ifdef BUS_BURST_READ_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    runBurst(32'hF0000000, 8'd3, 1, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (endOutCount - endOutBase !== 1 || endOutCyc !== beginCyc + 8)
      $display("FAIL timeout_end: pulses %0d at %0d, expected 1 at %0d", endOutCount - endOutBase, endOutCyc, beginCyc + 8);
    else passed++;
    checks++;
    if (doneCyc !== endOutCyc + 1 || doneErr !== 1'b1)
      $display("FAIL timeout_done: done %0d error %b, expected %0d 1", doneCyc, doneErr, endOutCyc + 1);
    else passed++;
  endtask
`endif

  initial begin
    bus.busGrantIn = 1'b0;
    bus.addressDataIn = '0;
    bus.dataValidIn = 1'b0;
    bus.endTransactionIn = 1'b0;
    bus.busErrorIn = 1'b0;
    test_reset();
    test_nominal();
    test_grant_delay();
    test_bus_error();
    test_short_burst();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef BUS_BURST_READ_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bus_burst_read_master.md
# bus_burst_read_master

Single-client burst-read master for the shared multiplexed address/data bus. Accepts a read request (start address, burst length) from a local client such as the boot loader or instruction fetch unit, arbitrates for the bus, issues one read burst to a slave (e.g. the BIOS ROM at 0xF0000000), and streams the returned words to the client with word indices. It also reports completion and error status.

## Interface
- TIMEOUT_CYCLES, 64: idle cycles allowed between beginning the burst and the next data word or end before abort. Only used with the watchdog compiled in.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- requestIn  in  1  client start pulse; sampled only in IDLE
- requestAddressIn  in  32  word-aligned start address
- requestBurstSizeIn  in  8  burst length minus one (0 = 1 word, 255 = 256 words)
- busyOut  out  1  request in progress
- dataOut  out  32  returned word
- dataValidOut  out  1  dataOut/wordIndexOut valid this cycle
- wordIndexOut  out  8  index of the word within the burst (0-based)
- doneOut  out  1  one-cycle completion pulse
- errorOut  out  1  status of the last burst; valid with doneOut, held until the next accept
- busRequestOut  out  1  request to the bus arbiter
- busGrantIn  in  1  arbiter grant
- addressDataIn  in  32  bus data
- dataValidIn, endTransactionIn, busErrorIn  in  1 each  bus control
- addressDataOut  out  32  bus address; 0 when not driving
- beginTransactionOut, readNotWriteOut, endTransactionOut  out  1 each  bus control; 0 when not driving
- byteEnablesOut  out  4  0xF during begin, else 0
- burstSizeOut  out  8  burst size during begin, else 0

## Operation
- All outputs are registered. Bus outputs are 0 whenever not actively driven, because the bus is wired-OR.
- Reset: the FSM goes to IDLE and every output is 0, including errorOut.
- States:
  - IDLE: on requestIn, latch the address and size, clear errorOut, and go to REQUEST.
  - REQUEST: busRequestOut=1. On busGrantIn, go to BEGIN.
  - BEGIN: for one cycle drive beginTransactionOut=1, readNotWriteOut=1, addressDataOut=address, burstSizeOut=size, byteEnablesOut=0xF. Go to RECEIVE.
  - RECEIVE: on each dataValidIn, register the word and present it with wordIndexOut = running count. The 9-bit counter starts at 0.
    - endTransactionIn → DONE. Set errorOut if the received count ≠ size+1.
    - busErrorIn → set errorOut and go to ERRWAIT.
    - dataValidIn beyond size+1 words → word is dropped and errorOut is set.
  - ERRWAIT: ignore data and wait for endTransactionIn, then go to DONE.
  - DONE: pulse doneOut for one cycle, drop busRequestOut, go to IDLE.
- busRequestOut stays high from REQUEST through DONE (exclusive). busyOut is high in every state except IDLE.
- A request arriving while busy is ignored (no queue).
- An address with bits[1:0] ≠ 0 is still issued. The slave answers with busErrorIn, which yields errorOut=1.
- If dataValidIn and endTransactionIn arrive in the same cycle, the word is delivered and then DONE is taken.

## Timing
- Cycle G: busGrantIn sampled. Cycle G+1: beginTransactionOut=1.
- A data word on the bus at cycle D appears on dataOut/dataValidOut at D+1.
- endTransactionIn at cycle E: doneOut=1 at E+1, busyOut=0 at E+2.
- requestIn at cycle R: busyOut=1 and busRequestOut=1 at R+1. With an immediate grant, begin is at R+3.
- Against a slave that returns its first word 3 cycles after begin (BIOS ROM), the first dataValidOut comes 4 cycles after beginTransactionOut.
- An asynchronous reset during any state returns to IDLE immediately, and all bus outputs go to 0 (no endTransactionOut is issued).

## Configuration
- BUS_BURST_READ_MASTER_TIMEOUT_EN defined: in RECEIVE or ERRWAIT, a 16-bit watchdog counts cycles with no dataValidIn and no endTransactionIn. It reloads on either.
  - On reaching TIMEOUT_CYCLES, the master drives endTransactionOut=1 for one cycle, sets errorOut, and goes to DONE the following cycle.
- Undefined: no watchdog. endTransactionOut is constant 0, and the master waits indefinitely.

## Test plan
- Request 0xF0000000, size 3, grant immediate, slave returns 4 words 0xA0..0xA3 then end → four dataValidOut with indices 0..3 and matching data; doneOut=1 one cycle; errorOut=0.
- Grant withheld 10 cycles → beginTransactionOut is asserted exactly one cycle after grant; no bus outputs are nonzero before then.
- Request address 0xF0000002, size 2; slave asserts busErrorIn until end → no dataValidOut; doneOut with errorOut=1.
- Size 3 but slave ends after 2 words → 2 words delivered; doneOut with errorOut=1.
- Assert reset while in RECEIVE after word 1 → next cycle all outputs 0 and busyOut=0; a new request succeeds normally.
- With BUS_BURST_READ_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave silent after begin → endTransactionOut pulse 8 cycles later, then doneOut with errorOut=1.
